// File: rtl/bsg_decode_with_v_buffered.sv
// Buffered binary-to-one-hot decoder: 2-entry valid/ready input FIFO, valid/yumi output,
// sticky OR of delivered grants. Define BSG_DECODE_RANGE_CHECK_EN to add err_o range/protocol flag.
module bsg_decode_with_v_buffered #(
    parameter int unsigned width_p    = 16,
    parameter int unsigned lg_width_p = $clog2(width_p)
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic [lg_width_p-1:0] addr_i,
    input  logic                  v_i,
    output logic                  ready_o,
    output logic [width_p-1:0]    o,
    output logic                  v_o,
    input  logic                  yumi_i,
    input  logic                  clear_i,
    output logic [width_p-1:0]    seen_o,
    output logic [1:0]            count_o
`ifdef BSG_DECODE_RANGE_CHECK_EN
    ,
    output logic                  err_o
`endif
);

    logic [1:0][lg_width_p-1:0] mem_q;
    logic                       head_q, tail_q;
    logic [1:0]                 count_q, count_d;
    logic [width_p-1:0]         seen_q, seen_d;
    logic [lg_width_p-1:0]      head_addr;
    logic                       enq, deq;

    assign ready_o = (count_q != 2'd2);
    assign v_o     = (count_q != 2'd0);
    assign count_o = count_q;
    assign seen_o  = seen_q;

    // yumi_i with nothing to deliver is a protocol error and must not disturb state
    assign enq = v_i & ready_o;
    assign deq = yumi_i & v_o;

    assign head_addr = mem_q[head_q];

    always_comb begin
        o = '0;
        for (int k = 0; k < width_p; k++) begin
            if (v_o && (head_addr == lg_width_p'(k))) o[k] = 1'b1;
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({enq, deq})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        seen_d = seen_q;
        if (clear_i) begin
            seen_d = deq ? o : '0;
        end else if (deq) begin
            seen_d = seen_q | o;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mem_q   <= '0;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
            seen_q  <= '0;
        end else begin
            if (enq) begin
                mem_q[tail_q] <= addr_i;
                tail_q        <= ~tail_q;
            end
            if (deq) head_q <= ~head_q;
            count_q <= count_d;
            seen_q  <= seen_d;
        end
    end

`ifdef BSG_DECODE_RANGE_CHECK_EN
    localparam logic [lg_width_p:0] WidthLim = (lg_width_p + 1)'(width_p);

    logic err_q, err_d, range_err, proto_err;

    assign range_err = enq && ({1'b0, addr_i} >= WidthLim);
    assign proto_err = yumi_i && !v_o;
    assign err_o     = err_q;

    // a new violation in the clearing cycle still wins
    always_comb begin
        err_d = err_q | range_err | proto_err;
        if (clear_i) err_d = range_err | proto_err;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
`ifndef SYNTHESIS
            if (range_err) $error("bsg_decode_with_v_buffered: index %0d out of range", addr_i);
            if (proto_err) $error("bsg_decode_with_v_buffered: yumi_i while v_o is low");
`endif
        end
    end
`endif

endmodule
